serial_chunk_adder: RTL and testbench

//  Multi-cycle parametrised adder: sums two WIDTH-bit operands plus carry-in,

---
 rtl/serial_chunk_adder_if.sv | 23 ++
 rtl/serial_chunk_adder.sv | 119 +++++++++++
 tb/tb_serial_chunk_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// rtl/serial_chunk_adder_if.sv - start/busy/done operand and result bundle for serial_chunk_adder
interface serial_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder, DIGIT bits per clock, LSB chunk first
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_chunk_adder_if.slave bus
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_chunk_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
    $error("serial_chunk_adder: interface WIDTH does not match adder WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [DIGIT:0]   chunk;
  logic [WIDTH-1:0] sum_next;

  // Adds the current low chunk of both operands plus the carry held from the previous chunk
  always_comb begin
    chunk = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  end

  if (DIGIT == WIDTH) begin : g_single_chunk
    // Whole word in one chunk: the chunk result is the full sum
    always_comb begin
      sum_next = chunk[DIGIT-1:0];
    end
  end else begin : g_multi_chunk
    // New chunk enters at the top; after NCHUNK shifts the first chunk reaches bit 0
    always_comb begin
      sum_next = {chunk[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end
  end

  // State, operand shift registers, carry, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic: capture on start in IDLE/DONE, one chunk per cycle in RUN
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = sum_next;
        carry_d = chunk[DIGIT];
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cout_d  = chunk[DIGIT];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb/tb_serial_chunk_adder.sv - table and scoreboard bench for serial_chunk_adder
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(8)) if0 ();
  serial_chunk_adder_if #(.WIDTH(8)) if1 ();
  serial_chunk_adder_if #(.WIDTH(4)) if2 ();

  serial_chunk_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  serial_chunk_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_chunk_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  typedef struct {
    logic [8:0] exp;
    int         acc;
  } sb_t;

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec_t;

  sb_t  q0[$];
  sb_t  q1[$];
  sb_t  q2[$];
  vec_t vt[11];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic sb_t qpop(input int sel);
    case (sel)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int sel, input logic [8:0] exp, input int acc);
    sb_t e;
    e.exp = exp;
    e.acc = acc;
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qclear(input int sel);
    case (sel)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  function automatic int lat(input int sel);
    case (sel)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    case (sel)
      0: begin if0.start = s; if0.a = a; if0.b = b; if0.cin = c; end
      1: begin if1.start = s; if1.a = a; if1.b = b; if1.cin = c; end
      default: begin if2.start = s; if2.a = a[3:0]; if2.b = b[3:0]; if2.cin = c; end
    endcase
  endtask

  task automatic mon(input int sel, input logic dn, input logic [8:0] res);
    sb_t e;
    if (dn === 1'b1) begin
      if (qsize(sel) == 0) begin
        chk($sformatf("unexpected_done_dut%0d", sel), {31'b0, dn}, 32'd0);
      end else begin
        e = qpop(sel);
        chk($sformatf("result_dut%0d", sel), {23'b0, res}, {23'b0, e.exp});
        chk($sformatf("latency_dut%0d", sel), cyc - e.acc, lat(sel));
      end
    end
  endtask

  // One clock: wait for the falling edge, then score every done pulse seen
  task automatic tick();
    @(negedge clk);
    cyc++;
    mon(0, if0.done, {if0.cout, if0.sum});
    mon(1, if1.done, {if1.cout, if1.sum});
    mon(2, if2.done, {4'b0, if2.cout, if2.sum});
  endtask

  task automatic wait_empty(input int sel, input int budget);
    for (int i = 0; i < budget && qsize(sel) != 0; i++) tick();
    chk($sformatf("drain_dut%0d", sel), qsize(sel), 0);
    qclear(sel);
  endtask

  // Start at the next edge; operands are scrambled afterwards and must not matter
  task automatic start_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] exp);
    set_in(sel, 1'b1, a, b, c);
    qpush(sel, exp, cyc + 1);
    tick();
    set_in(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic chk_zero(input int sel);
    case (sel)
      0: chk("reset_dut0", {20'b0, if0.busy, if0.done, if0.cout, if0.sum}, 32'd0);
      1: chk("reset_dut1", {20'b0, if1.busy, if1.done, if1.cout, if1.sum}, 32'd0);
      default: chk("reset_dut2", {24'b0, if2.busy, if2.done, if2.cout, if2.sum}, 32'd0);
    endcase
  endtask

  initial begin
    vt[0]  = '{0, 8'hFF, 8'h01, 1'b0, 9'h100};
    vt[1]  = '{0, 8'h00, 8'h00, 1'b0, 9'h000};
    vt[2]  = '{0, 8'h00, 8'h00, 1'b1, 9'h001};
    vt[3]  = '{0, 8'hFF, 8'hFF, 1'b1, 9'h1FF};
    vt[4]  = '{0, 8'h12, 8'h34, 1'b0, 9'h046};
    vt[5]  = '{0, 8'hA5, 8'h5A, 1'b1, 9'h100};
    vt[6]  = '{1, 8'h3C, 8'h25, 1'b1, 9'h062};
    vt[7]  = '{1, 8'hFF, 8'h00, 1'b1, 9'h100};
    vt[8]  = '{1, 8'h7F, 8'h01, 1'b0, 9'h080};
    vt[9]  = '{1, 8'h99, 8'h99, 1'b0, 9'h132};
    vt[10] = '{1, 8'h0F, 8'h01, 1'b0, 9'h010};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    for (int s = 0; s < 3; s++) chk_zero(s);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      start_op(vt[i].sel, vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);
      wait_empty(vt[i].sel, 20);
    end

    // start held high: second pair is captured in the DONE cycle with no idle bubble
    set_in(0, 1'b1, 8'h01, 8'h01, 1'b0);
    qpush(0, 9'h002, cyc + 1);
    tick();
    set_in(0, 1'b1, 8'h80, 8'h80, 1'b0);
    qpush(0, 9'h100, cyc + 1 + 8);
    repeat (9) tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_empty(0, 20);

    // start pulsed while busy is ignored; busy stays high, one done only
    start_op(0, 8'h11, 8'h22, 1'b0, 9'h033);
    repeat (3) tick();
    set_in(0, 1'b1, 8'hAA, 8'hAA, 1'b1);
    tick();
    chk("busy_during_ignored_start", {31'b0, if0.busy}, 32'd1);
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("busy_after_ignored_start", {31'b0, if0.busy}, 32'd1);
    wait_empty(0, 20);
    repeat (12) tick();

    // reset in the fourth RUN cycle aborts silently
    start_op(0, 8'h5A, 8'h33, 1'b0, 9'h08D);
    repeat (3) tick();
    chk("busy_before_abort", {31'b0, if0.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {21'b0, if0.busy, if0.done, if0.cout, if0.sum}, 32'd0);
    qclear(0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    start_op(0, 8'h5A, 8'h33, 1'b0, 9'h08D);
    wait_empty(0, 20);

    // DIGIT == WIDTH: exhaustive 4-bit registered full adder
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          start_op(2, 8'(a), 8'(b), 1'(c), 9'(a + b + c));
          wait_empty(2, 6);
        end
      end
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
